// File: rtl/line_fill_engine.sv
// line_fill_engine: single-outstanding bus engine for L1 line fills and
// dirty-line writebacks; assembles fill beats into a line pulse.
`ifndef MEM_READ
`define MEM_READ 13'h1
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 13'h2
`endif

module line_fill_engine #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH = 13,
    parameter int ADDRESS_SIZE = 64,
    parameter int BEATS = 8,
    parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG = `MEM_READ,
    parameter logic [BUS_TAG_WIDTH-1:0] WRITE_TAG = `MEM_WRITE
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            fill_req,
    input  logic [ADDRESS_SIZE-1:0]         fill_addr,
    output logic                            fill_ready,
    output logic                            line_valid,
    output logic [ADDRESS_SIZE-1:0]         line_addr,
    output logic [BEATS*BUS_DATA_WIDTH-1:0] line_data,
    input  logic                            wb_req,
    input  logic [ADDRESS_SIZE-1:0]         wb_addr,
    input  logic [BEATS*BUS_DATA_WIDTH-1:0] wb_data,
    output logic                            wb_ready,
    output logic                            wb_done,
    output logic                            bus_reqcyc,
    input  logic                            bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0]       bus_req,
    output logic [BUS_TAG_WIDTH-1:0]        bus_reqtag,
    input  logic                            bus_respcyc,
    output logic                            bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0]       bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]        bus_resptag
);

    localparam int CW = $clog2(BEATS);
    localparam int CNT_W = CW + 1;
    localparam logic [ADDRESS_SIZE-1:0] LMASK = ADDRESS_SIZE'(BEATS * 8 - 1);

    typedef enum logic [2:0] {
        IDLE,
        WB_ADDR,
        WB_DATA,
        RD_REQ,
        RD_RESP
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [ADDRESS_SIZE-1:0]   addr_q;
    logic [BUS_DATA_WIDTH-1:0] wb_q   [BEATS];
    logic [BUS_DATA_WIDTH-1:0] fill_q [BEATS];

    logic [ADDRESS_SIZE-1:0] aligned;
    logic [CW-1:0]           slot;
    logic                    resp_hit;
    logic                    last_beat;

    assign aligned    = addr_q & ~LMASK;
    assign slot       = cnt_q[CW-1:0];
    assign resp_hit   = bus_respcyc && (bus_resptag == READ_TAG);
    assign last_beat  = (cnt_q == CNT_W'(BEATS - 1));
    assign fill_ready = (state_q == IDLE);
    assign wb_ready   = (state_q == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request side is combinational from state so reqcyc rises the cycle after acceptance.
    always_comb begin
        state_d    = state_q;
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
        unique case (state_q)
            IDLE: begin
                if (wb_req) begin
                    state_d = WB_ADDR;
                end else if (fill_req) begin
                    state_d = RD_REQ;
                end
            end
            WB_ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = BUS_DATA_WIDTH'(aligned);
                bus_reqtag = WRITE_TAG;
                if (bus_reqack) state_d = WB_DATA;
            end
            WB_DATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = wb_q[slot];
                bus_reqtag = WRITE_TAG;
                if (bus_reqack && last_beat) state_d = IDLE;
            end
            RD_REQ: begin
                bus_reqcyc = 1'b1;
                bus_req    = BUS_DATA_WIDTH'(aligned);
                bus_reqtag = READ_TAG;
                if (bus_reqack) state_d = RD_RESP;
            end
            RD_RESP: begin
                if (resp_hit && last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            bus_respack <= 1'b0;
            line_valid  <= 1'b0;
            wb_done     <= 1'b0;
            line_addr   <= '0;
            line_data   <= '0;
            for (int k = 0; k < BEATS; k++) begin
                wb_q[k]   <= '0;
                fill_q[k] <= '0;
            end
        end else begin
            bus_respack <= bus_respcyc;
            line_valid  <= 1'b0;
            wb_done     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (wb_req) begin
                        addr_q <= wb_addr;
                        for (int k = 0; k < BEATS; k++) begin
                            wb_q[k] <= wb_data[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                        end
                    end else if (fill_req) begin
                        addr_q <= fill_addr;
                    end
                end
                WB_ADDR: begin
                    if (bus_reqack) cnt_q <= '0;
                end
                WB_DATA: begin
                    if (bus_reqack) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_beat) wb_done <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (bus_reqack) cnt_q <= '0;
                end
                RD_RESP: begin
                    if (resp_hit) begin
                        fill_q[slot] <= bus_resp;
                        cnt_q        <= cnt_q + 1'b1;
                        // The final beat bypasses the buffer straight into the line.
                        if (last_beat) begin
                            line_valid <= 1'b1;
                            line_addr  <= aligned;
                            for (int k = 0; k < BEATS; k++) begin
                                line_data[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <=
                                    (CW'(k) == slot) ? bus_resp : fill_q[k];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_engine.sv
// tb_line_fill_engine: directed and randomized fills/writebacks checked
// against a transaction-level model of the bus sequence and returned line.
module tb_line_fill_engine;

    localparam logic [12:0] RT = 13'h1;
    localparam logic [12:0] WT = 13'h2;

    logic         clk = 1'b0;
    logic         reset;
    logic         fill_req;
    logic [63:0]  fill_addr;
    logic         fill_ready;
    logic         line_valid;
    logic [63:0]  line_addr;
    logic [511:0] line_data;
    logic         wb_req;
    logic [63:0]  wb_addr;
    logic [511:0] wb_data;
    logic         wb_ready;
    logic         wb_done;
    logic         bus_reqcyc;
    logic         bus_reqack;
    logic [63:0]  bus_req;
    logic [12:0]  bus_reqtag;
    logic         bus_respcyc;
    logic         bus_respack;
    logic [63:0]  bus_resp;
    logic [12:0]  bus_resptag;

    int total = 0;
    int bad = 0;

    line_fill_engine #(
        .READ_TAG(RT),
        .WRITE_TAG(WT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fill_req(fill_req),
        .fill_addr(fill_addr),
        .fill_ready(fill_ready),
        .line_valid(line_valid),
        .line_addr(line_addr),
        .line_data(line_data),
        .wb_req(wb_req),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .wb_ready(wb_ready),
        .wb_done(wb_done),
        .bus_reqcyc(bus_reqcyc),
        .bus_reqack(bus_reqack),
        .bus_req(bus_req),
        .bus_reqtag(bus_reqtag),
        .bus_respcyc(bus_respcyc),
        .bus_respack(bus_respack),
        .bus_resp(bus_resp),
        .bus_resptag(bus_resptag)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle; every response beat must be acked exactly one cycle later.
    task automatic tick();
        logic p;
        p = bus_respcyc;
        @(negedge clk);
        chk("respack", 512'(bus_respack), 512'(p));
    endtask

    function automatic logic [63:0] aln(input logic [63:0] a);
        return a & ~64'h3f;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = {$urandom, $urandom};
        return l;
    endfunction

    task automatic run_fill(input logic [63:0] a, input logic [511:0] line,
                            input int stall, input int gap);
        fill_req = 1'b1;
        fill_addr = a;
        tick();
        fill_req = 1'b0;
        chk("fill_pulses_low", 512'({line_valid, wb_done}), 512'(0));
        chk("fill_ready_busy", 512'({fill_ready, wb_ready}), 512'(0));
        for (int i = 0; i <= stall; i++) begin
            chk("rd_reqcyc", 512'(bus_reqcyc), 512'(1));
            chk("rd_addr", 512'(bus_req), 512'(aln(a)));
            chk("rd_tag", 512'(bus_reqtag), 512'(RT));
            if (i == stall) bus_reqack = 1'b1;
            tick();
        end
        bus_reqack = 1'b0;
        chk("rd_req_drop", 512'({bus_reqcyc, bus_req, bus_reqtag}), 512'(0));
        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < gap; g++) begin
                bus_respcyc = 1'($urandom_range(0, 1));
                bus_resptag = WT;
                bus_resp = {$urandom, $urandom};
                tick();
                chk("gap_no_line", 512'({line_valid, fill_ready}), 512'(0));
            end
            bus_respcyc = 1'b1;
            bus_resptag = RT;
            bus_resp = line[k*64 +: 64];
            tick();
            bus_respcyc = 1'b0;
            if (k < 7) chk("early_line", 512'(line_valid), 512'(0));
        end
        chk("line_valid", 512'(line_valid), 512'(1));
        chk("line_addr", 512'(line_addr), 512'(aln(a)));
        chk("line_data", line_data, line);
        chk("fill_ready_back", 512'({fill_ready, wb_ready}), 512'(3));
    endtask

    task automatic run_wb(input logic [63:0] a, input logic [511:0] line, input int ackp);
        logic [63:0] exp_req [9];
        int idx;
        int cyc;
        logic ack;
        exp_req[0] = aln(a);
        for (int k = 0; k < 8; k++) exp_req[k+1] = line[k*64 +: 64];
        wb_req = 1'b1;
        wb_addr = a;
        wb_data = line;
        tick();
        wb_req = 1'b0;
        chk("wb_pulses_low", 512'({line_valid, wb_done}), 512'(0));
        idx = 0;
        cyc = 0;
        while (idx < 9 && cyc < 300) begin
            chk("wb_reqcyc", 512'(bus_reqcyc), 512'(1));
            chk("wb_ready_busy", 512'({fill_ready, wb_ready}), 512'(0));
            ack = (ackp == 0) || ($urandom_range(0, ackp) == 0);
            if (ack) begin
                chk("wb_req", 512'(bus_req), 512'(exp_req[idx]));
                chk("wb_tag", 512'(bus_reqtag), 512'(WT));
                idx++;
            end
            bus_reqack = ack;
            tick();
            cyc++;
        end
        bus_reqack = 1'b0;
        if (idx < 9) chk("wb_timeout", 512'(idx), 512'(9));
        chk("wb_done", 512'(wb_done), 512'(1));
        chk("wb_reqcyc_drop", 512'(bus_reqcyc), 512'(0));
        chk("wb_ready_back", 512'({fill_ready, wb_ready}), 512'(3));
    endtask

    initial begin
        logic [511:0] l;
        logic [511:0] held;
        reset = 1'b0;
        fill_req = 1'b0;
        fill_addr = '0;
        wb_req = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        bus_reqack = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp = '0;
        bus_resptag = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_bus", 512'({bus_reqcyc, bus_respack, bus_req, bus_reqtag}), 512'(0));
        chk("rst_pulses", 512'({line_valid, wb_done}), 512'(0));
        chk("rst_line", line_data, 512'(0));
        chk("rst_laddr", 512'(line_addr), 512'(0));
        chk("rst_ready", 512'({fill_ready, wb_ready}), 512'(3));
        reset = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) l[k*64 +: 64] = 64'h10 + 64'(k);
        run_fill(64'h1234, l, 0, 0);
        held = l;
        tick();
        chk("line_pulse_one", 512'(line_valid), 512'(0));
        tick();
        chk("line_hold", line_data, held);

        for (int k = 0; k < 8; k++) l[k*64 +: 64] = 64'hA0 + 64'(k);
        run_wb(64'h40, l, 0);
        tick();
        chk("wb_pulse_one", 512'(wb_done), 512'(0));

        fill_req = 1'b1;
        fill_addr = 64'h2fc0_0013;
        run_wb(64'h7777_0080, rand_line(), 1);
        run_fill(64'h2fc0_0013, rand_line(), 1, 0);

        run_fill(64'hdead_beef, rand_line(), 5, 3);

        fill_req = 1'b1;
        fill_addr = 64'h5555;
        tick();
        fill_req = 1'b0;
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_respcyc = 1'b1;
            bus_resptag = RT;
            bus_resp = {$urandom, $urandom};
            tick();
        end
        bus_respcyc = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst_bus", 512'({bus_reqcyc, bus_respack, bus_req, bus_reqtag}), 512'(0));
        chk("arst_pulses", 512'({line_valid, wb_done}), 512'(0));
        chk("arst_line", line_data, 512'(0));
        chk("arst_ready", 512'({fill_ready, wb_ready}), 512'(3));
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_quiet", 512'({line_valid, bus_reqcyc}), 512'(0));
        end
        run_fill(64'h80, rand_line(), 0, 0);

        tick();
        bus_respcyc = 1'b1;
        bus_resptag = RT;
        bus_resp = {$urandom, $urandom};
        tick();
        bus_respcyc = 1'b0;
        chk("stray_resp", 512'({line_valid, fill_ready, bus_reqcyc}), 512'(2));
        tick();
        chk("stray_resp2", 512'({line_valid, fill_ready, bus_reqcyc}), 512'(2));

        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        chk("stray_ack", 512'({bus_reqcyc, fill_ready, wb_done}), 512'(2));

        for (int i = 0; i < 30; i++) begin
            tick();
            if ($urandom_range(0, 1) == 0) begin
                run_fill({$urandom, $urandom}, rand_line(),
                         int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
            end else begin
                run_wb({$urandom, $urandom}, rand_line(), int'($urandom_range(0, 2)));
            end
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
